store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Posted-write FIFO between the single-cycle MIPS core and data memory. Queues word stores
//  (memwrite/dataadr/writedata) and drains them to a memory write port that may stall (mem_wready).
//  Loads read memory through a separate combinational read port; the buffer checks for address
//  hazards against pending stores. Sits directly downstream of the core and upstream of data memory.
// PARAMETERS
//  DEPTH  4   entries; power of two, >= 2
//  AW     32  byte-address width
//  DW     32  data width (word stores only)
// PORTS
//  clk        in   1         system clock, rising edge
//  rst        in   1         asynchronous, active-low reset
//  cpu_we     in   1         store request (core memwrite)
//  cpu_re     in   1         load request
//  cpu_addr   in   AW        byte address (core dataadr); bits [1:0] ignored
//  cpu_wdata  in   DW        store data (core writedata)
//  cpu_rdata  out  DW        load data, combinational
//  stall      out  1         hold core PC/regfile this cycle
//  mem_we     out  1         write valid toward memory
//  mem_waddr  out  AW        head-entry address ({addr,2'b00})
//  mem_wdata  out  DW        head-entry data
//  mem_wready in   1         memory accepts write this cycle
//  mem_raddr  out  AW        load address (= cpu_addr)
//  mem_rdata  in   DW        memory read data, combinational
//  count      out  clog2(DEPTH+1)  occupied entries
// BEHAVIOUR
//  - Reset (async, rst=0): head=tail=count=0, all entries invalid; mem_we=0, stall=0 immediately.
//    Pending stores are discarded; no partial drain completes.
//  - Push: cpu_we & ~stall -> entry {cpu_addr[AW-1:2], cpu_wdata} written at tail on clk edge; tail++.
//  - Pop: mem_we = (count!=0); head entry driven on mem_waddr/mem_wdata; mem_we & mem_wready -> head++.
//  - Push and pop in same cycle: count unchanged, both pointers advance. Pointers wrap DEPTH-1 -> 0.
//  - Full: stall = (count==DEPTH) & cpu_we; no same-cycle bypass of a concurrent pop. Store retried next cycle.
//  - Empty: mem_we=0; a push becomes visible at mem_we the following cycle (1-cycle latency minimum).
//  - No coalescing: repeated stores to one address occupy separate entries, drain in program order.
//  - Load hit = any valid entry with addr == cpu_addr[AW-1:2] (entry being popped this cycle counts).
//  - Load miss: cpu_rdata = mem_rdata, stall=0.
//  - cpu_we & cpu_re together is illegal; bench asserts it never occurs; store takes priority.
//  - Order: memory sees writes in exactly push order; no store lost or duplicated under any mem_wready pattern.
// CONFIGURATION
//  STORE_BUF_FWD_EN defined: load hit -> cpu_rdata = data of YOUNGEST matching entry, stall=0.
//  Not defined: load hit -> stall=1 each cycle until no matching entry remains, then cpu_rdata=mem_rdata.
// STRUCTURE
//  store_buf_pkg: sb_entry_t {waddr[AW-3:0], data[DW-1:0]}, WORD_LSB=2, PTR_W=$clog2(DEPTH), CNT_W.
//  Sub-module sb_match: parallel addr compare + youngest-first priority select (relative to tail);
//  outputs hit and hit_data. Instantiated in both configurations (hit_data unused without FWD).
//  Top: entry array, head/tail/count regs, stall/forward mux.
// TESTING
//  1 rst low mid-drain with count=3 -> count=0, mem_we=0 same cycle, no further memory writes after release.
//  2 DEPTH=4, mem_wready=0, 5 stores 0x10..0x20 -> 4 accepted, 5th stall=1; wready=1 -> writes in order, 5th accepted next.
//  3 Store 0x40<-0xAAAA, 0x40<-0xBBBB, wready=0, load 0x40 -> FWD_EN: rdata=0xBBBB stall=0; else stall until both drained.
//  4 Load 0x44 with only 0x40 pending, mem_rdata=0x1234 -> rdata=0x1234, stall=0.
//  5 Steady push+pop every cycle for 20 cycles across pointer wrap -> count constant, memory trace equals push trace.
//  6 Random wready (50%) + random stores/loads, scoreboard vs reference memory -> all loads match, zero lost stores.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the posted-write store buffer.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_AW    = 32;
  localparam int unsigned SB_DW    = 32;
  localparam int unsigned WORD_LSB = 2;
  localparam int unsigned PTR_W    = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W    = $clog2(SB_DEPTH + 1);

  // One queued word store: word address plus data.
  typedef struct packed {
    logic [SB_AW-WORD_LSB-1:0] waddr;
    logic [SB_DW-1:0]          data;
  } sb_entry_t;

  // Expand a word address back to a byte address.
  function automatic logic [SB_AW-1:0] word_to_byte(input logic [SB_AW-WORD_LSB-1:0] w);
    return {w, {WORD_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Core-side and memory-side signals of the store buffer.
// slave: the buffer itself; master: the core plus data memory around it.
interface store_buffer_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          cpu_we;
  logic          cpu_re;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          stall;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wready;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_we, cpu_re, cpu_addr, cpu_wdata, mem_wready, mem_rdata,
    output cpu_rdata, stall, mem_we, mem_waddr, mem_wdata, mem_raddr
  );

  modport master (
    output cpu_we, cpu_re, cpu_addr, cpu_wdata, mem_wready, mem_rdata,
    input  cpu_rdata, stall, mem_we, mem_waddr, mem_wdata, mem_raddr
  );
endinterface

// File: rtl/store_buffer_match.sv
// Load-address hazard detector: compares the load word address against all
// valid entries and selects the youngest match (closest behind tail).
module sb_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW
) (
  input  sb_entry_t                    entries [DEPTH],
  input  logic [DEPTH-1:0]             valid,
  input  logic [$clog2(DEPTH)-1:0]     tail,
  input  logic [AW-WORD_LSB-1:0]       addr,
  output logic                         hit,
  output logic [SB_DW-1:0]             hit_data
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk from tail-1 (youngest) back to tail (oldest); first match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      idx = tail - PW'(k);
      if (!hit && valid[idx] && (entries[idx].waddr == addr)) begin
        hit      = 1'b1;
        hit_data = entries[idx].data;
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core and data memory. Stores are queued and
// drained in order through a stallable write port; loads bypass through the
// combinational read port after an address-hazard check against the queue.
// Optional macro STORE_BUF_FWD_EN: forward the youngest matching entry to a
// load instead of stalling until matching entries have drained.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW
) (
  input  logic                         clk,
  input  logic                         rst,
  store_buffer_if.slave                bus,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  sb_entry_t              entries [DEPTH];
  logic [PW-1:0]          head;
  logic [PW-1:0]          tail;
  logic [DEPTH-1:0]       valid;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic                   hit;
  logic [DW-1:0]          hit_data;
  logic                   stall_w;
  logic [AW-WORD_LSB-1:0] req_waddr;

  assign req_waddr = bus.cpu_addr[AW-1:WORD_LSB];
  assign full      = (count == CW'(DEPTH));
  assign push      = bus.cpu_we & ~stall_w;
  assign pop       = bus.mem_we & bus.mem_wready;

  assign bus.mem_we    = (count != '0);
  assign bus.mem_waddr = word_to_byte(entries[head].waddr);
  assign bus.mem_wdata = entries[head].data;
  assign bus.mem_raddr = bus.cpu_addr;
  assign bus.stall     = stall_w;

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid[i] = (CW'(PW'(i) - head) < count);
    end
  end

  sb_match #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_match (
    .entries  (entries),
    .valid    (valid),
    .tail     (tail),
    .addr     (req_waddr),
    .hit      (hit),
    .hit_data (hit_data)
  );

`ifdef STORE_BUF_FWD_EN
  // Loads never stall; a hit returns the youngest pending data.
  always_comb begin
    stall_w = 1'b0;
    if (bus.cpu_we) begin
      stall_w = full;
    end
  end

  assign bus.cpu_rdata = hit ? hit_data : bus.mem_rdata;
`else
  // A load hit holds the core until every matching store has drained.
  always_comb begin
    stall_w = 1'b0;
    if (bus.cpu_we) begin
      stall_w = full;
    end else if (bus.cpu_re) begin
      stall_w = hit;
    end
  end

  assign bus.cpu_rdata = bus.mem_rdata;

  logic unused_hit_data;
  assign unused_hit_data = ^hit_data;
`endif

  // Pointer and occupancy bookkeeping; reset discards all pending stores.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload storage; validity is tracked by head/count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[tail] <= '{waddr: req_waddr, data: bus.cpu_wdata};
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a queue-based model of pending
// stores plus an architectural memory checks every cycle, and directed
// sequences pin key values with literal expectations.
module tb_store_buffer;
  localparam int unsigned DEPTH = 4;
`ifdef STORE_BUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] count;

  store_buffer_if #(.AW(32), .DW(32)) bus ();

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] physmem  [64] = '{default: 32'h0};
  logic [31:0] arch_mem [64] = '{default: 32'h0};
  ent_t        mq [$];
  logic [31:0] trace_addr [$];
  int          wr_count = 0;
  bit          rnd_wr = 1'b0;

  assign bus.mem_rdata = physmem[bus.cpu_addr[7:2]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle model comparison and commit of the cycle's memory traffic.
  always @(negedge clk) begin
    logic        m_hit;
    logic [31:0] m_fwd;
    logic        m_stall;
    logic [5:0]  ix;
    if (!rst) begin
      chk("rst_count", count, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_stall", bus.stall, 0);
      mq.delete();
      arch_mem = physmem;
    end else begin
      assert (!(bus.cpu_we && bus.cpu_re)) else $error("store and load requested together");
      ix    = bus.cpu_addr[7:2];
      m_hit = 1'b0;
      m_fwd = '0;
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!m_hit && (mq[i].a[31:2] == bus.cpu_addr[31:2])) begin
          m_hit = 1'b1;
          m_fwd = mq[i].d;
        end
      end
      m_stall = bus.cpu_we ? (mq.size() == DEPTH) : (bus.cpu_re && m_hit && !FWD);
      chk("count", count, mq.size());
      chk("mem_we", bus.mem_we, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("mem_waddr", bus.mem_waddr, {mq[0].a[31:2], 2'b00});
        chk("mem_wdata", bus.mem_wdata, mq[0].d);
      end
      chk("stall", bus.stall, m_stall);
      chk("mem_raddr", bus.mem_raddr, bus.cpu_addr);
      if (bus.cpu_re && !bus.cpu_we && !bus.stall) begin
        chk("cpu_rdata", bus.cpu_rdata, (FWD && m_hit) ? m_fwd : physmem[ix]);
        chk("load_arch", bus.cpu_rdata, arch_mem[ix]);
      end
      if (bus.mem_we && bus.mem_wready) begin
        physmem[bus.mem_waddr[7:2]] = bus.mem_wdata;
        trace_addr.push_back(bus.mem_waddr);
        wr_count++;
        if (mq.size() != 0) void'(mq.pop_front());
      end
      if (bus.cpu_we && !bus.stall) begin
        mq.push_back('{a: {bus.cpu_addr[31:2], 2'b00}, d: bus.cpu_wdata});
        arch_mem[ix] = bus.cpu_wdata;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_wr) bus.mem_wready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle();
    bus.cpu_we = 1'b0;
    bus.cpu_re = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    bit done = 1'b0;
    bus.cpu_we    = 1'b1;
    bus.cpu_re    = 1'b0;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      done = !bus.stall;
      step();
    end
    chk("store_accepted", done, 1);
    idle();
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] d, output int cyc);
    bit done = 1'b0;
    d   = '0;
    cyc = 0;
    bus.cpu_we   = 1'b0;
    bus.cpu_re   = 1'b1;
    bus.cpu_addr = a;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      cyc++;
      done = !bus.stall;
      d    = bus.cpu_rdata;
      step();
    end
    chk("load_done", done, 1);
    idle();
  endtask

  task automatic drain();
    bus.mem_wready = 1'b1;
    for (int i = 0; i < 64 && count != 0; i++) step();
    chk("drain_empty", count, 0);
  endtask

  initial begin
    logic [31:0] d;
    int          cyc;
    int          base;
    int          wc;
    int          pushes;
    logic [31:0] exp_a [$];

    idle();
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    bus.mem_wready = 1'b0;
    rst = 1'b0;
    step();
    step();
    chk("reset_count", count, 0);
    chk("reset_mem_we", bus.mem_we, 0);
    rst = 1'b1;
    step();

    // Reset in the middle of a drain discards the queue immediately.
    bus.mem_wready = 1'b0;
    do_store(32'h80, 32'h11);
    do_store(32'h84, 32'h22);
    do_store(32'h88, 32'h33);
    chk("t1_count3", count, 3);
    bus.mem_wready = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("t1_async_count", count, 0);
    chk("t1_async_mem_we", bus.mem_we, 0);
    wc = wr_count;
    step();
    step();
    rst = 1'b1;
    repeat (5) step();
    chk("t1_no_write_after_rst", wr_count, wc);
    chk("t1_drained_one", physmem[6'h20], 32'h11);
    chk("t1_discarded", physmem[6'h21], 32'h0);

    // Full buffer stalls the fifth store, which is accepted once space frees.
    bus.mem_wready = 1'b0;
    base = trace_addr.size();
    for (int i = 0; i < 4; i++) do_store(32'h10 + 32'(4 * i), 32'h100 + 32'(i));
    chk("t2_full_count", count, 4);
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'h20;
    bus.cpu_wdata = 32'h104;
    @(negedge clk);
    chk("t2_full_stall", bus.stall, 1);
    step();
    bus.mem_wready = 1'b1;
    do_store(32'h20, 32'h104);
    drain();
    chk("t2_write_count", trace_addr.size() - base, 5);
    for (int i = 0; i < 5; i++) chk("t2_order", trace_addr[base + i], 32'h10 + 32'(4 * i));
    chk("t2_last_data", physmem[6'h08], 32'h104);

    // Two stores to one address, then a load of it.
    bus.mem_wready = 1'b0;
    do_store(32'h40, 32'hAAAA);
    do_store(32'h40, 32'hBBBB);
`ifdef STORE_BUF_FWD_EN
    bus.cpu_re   = 1'b1;
    bus.cpu_addr = 32'h40;
    @(negedge clk);
    chk("t3_fwd_stall", bus.stall, 0);
    chk("t3_fwd_rdata", bus.cpu_rdata, 32'hBBBB);
    step();
    idle();
`else
    bus.cpu_re   = 1'b1;
    bus.cpu_addr = 32'h40;
    @(negedge clk);
    chk("t3_hazard_stall", bus.stall, 1);
    step();
    bus.mem_wready = 1'b1;
    do_load(32'h40, d, cyc);
    chk("t3_rdata", d, 32'hBBBB);
    chk("t3_cycles", cyc, 3);
    chk("t3_count", count, 0);
`endif
    drain();
    chk("t3_mem", physmem[6'h10], 32'hBBBB);

    // Load to an address with no pending store reads memory without stalling.
    bus.mem_wready = 1'b1;
    do_store(32'h44, 32'h1234);
    drain();
    bus.mem_wready = 1'b0;
    do_store(32'h40, 32'h5555);
    do_load(32'h44, d, cyc);
    chk("t4_rdata", d, 32'h1234);
    chk("t4_cycles", cyc, 1);
    drain();

    // Steady push and pop every cycle across pointer wrap.
    bus.mem_wready = 1'b0;
    base = trace_addr.size();
    exp_a.delete();
    do_store(32'hC0, 32'h0);
    exp_a.push_back(32'hC0);
    do_store(32'hC4, 32'h1);
    exp_a.push_back(32'hC4);
    bus.mem_wready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d = 32'hC0 + ((32'(4 * (i + 2))) & 32'h3F);
      do_store(d, 32'(i + 2));
      exp_a.push_back(d);
      chk("t5_steady_count", count, 2);
    end
    drain();
    chk("t5_write_count", trace_addr.size() - base, 22);
    for (int i = 0; i < 22; i++) chk("t5_order", trace_addr[base + i], exp_a[i]);

    // Random traffic with random write-port backpressure.
    wc     = wr_count;
    pushes = 0;
    rnd_wr = 1'b1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 2))
        0: step();
        1: begin
          do_store(32'(4 * $urandom_range(0, 7)), $urandom);
          pushes++;
        end
        default: do_load(32'(4 * $urandom_range(0, 7)), d, cyc);
      endcase
    end
    rnd_wr = 1'b0;
    drain();
    chk("t6_no_lost_stores", wr_count - wc, pushes);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
